// File: rtl/addsub_pkg.sv
// Shared constants and FSM state type for the serial add/subtract unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit ripple adder slice with carry into the top bit.
// Latency: purely combinational.
// Backpressure: none; the caller decides when sum/cout are captured.
module addsub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] full;

  assign full  = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  assign sum   = full[CHUNK-1:0];
  assign cout  = full[CHUNK];
  // Carry into the top bit falls out of the top bit's own sum equation,
  // which avoids slicing below the MSB when CHUNK is 1.
  assign c_msb = x[CHUNK-1] ^ y[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, with flags.
// Latency: done pulses NCHUNK clocks after the accepting edge; one op per NCHUNK+1 cycles.
// Backpressure: start is ignored while busy; a new op may start in the DONE cycle.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $fatal(1, "addsub_serial: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;      // augend/minuend, shifted right one chunk per cycle
  logic [WIDTH-1:0] b_q;      // b or ~b, shifted the same way
  logic [WIDTH-1:0] work;     // partial sum, chunks enter at the top
  logic             cin_q;
  logic             mode_q;

  logic [CHUNK-1:0] sum;
  logic             cout;
  logic             c_msb;
  logic [WIDTH-1:0] next_work;

  addsub_slice #(.CHUNK(CHUNK)) u_slice (
    .x     (a_q[CHUNK-1:0]),
    .y     (b_q[CHUNK-1:0]),
    .cin   (cin_q),
    .sum   (sum),
    .cout  (cout),
    .c_msb (c_msb)
  );

  // After NCHUNK shifts the first chunk has reached bit 0, so the final
  // next_work is the complete result; also degenerates to sum when NCHUNK=1.
  assign next_work = WIDTH'({sum, work} >> CHUNK);

  // Control FSM, operand shifting and registered result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work     <= '0;
      cin_q    <= 1'b0;
      mode_q   <= MODE_ADD;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= (mode == MODE_SUB) ? ~b : b;
            cin_q  <= (mode == MODE_SUB);
            mode_q <= mode;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          cin_q <= cout;
          work  <= next_work;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            result   <= next_work;
            carry    <= cout;
            borrow   <= (mode_q == MODE_SUB) & ~cout;
            overflow <= c_msb ^ cout;
            zero     <= (next_work == '0);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=16, CHUNK=4).
// Latency: checks done arrives exactly NCHUNK clocks after the accepting edge.
// Backpressure: exercises start-while-busy, back-to-back starts and mid-op reset.
module tb_addsub_serial;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             borrow;
  logic             overflow;
  logic             zero;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        bo;
    logic        ov;
    logic        z;
  } exp_t;

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input logic m, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int ux, uy, sx, sy, ur, sr;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    if (m == 1'b0) begin
      ur   = ux + uy;
      sr   = sx + sy;
      e.c  = (ur > 65535);
      e.bo = 1'b0;
    end else begin
      ur   = ux - uy;
      sr   = sx - sy;
      e.c  = (ux >= uy);
      e.bo = (ux < uy);
    end
    e.res = ur[15:0];
    e.ov  = (sr > 32767) || (sr < -32768);
    e.z   = (e.res == 16'h0000);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Launches one op at the current negedge and returns at the negedge where done is high.
  task automatic run_op(input string tag, input logic m, input logic [15:0] x,
                        input logic [15:0] y, input bit poke);
    exp_t        e;
    logic [15:0] prev;
    int          lat;
    e    = model(m, x, y);
    prev = result;
    mode = m;
    a    = x;
    b    = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    a     = 16'($urandom);
    b     = 16'($urandom);
    chk({tag, "/busy"}, busy, 1);
    chk({tag, "/no_overlap"}, done, 0);
    lat = 0;
    while (done !== 1'b1 && lat < 3 * NCHUNK) begin
      if (poke && lat == 1) begin
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      chk({tag, "/hold"}, result, prev);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, "/latency"}, lat, NCHUNK);
    chk({tag, "/busy_end"}, busy, 0);
    chk({tag, "/result"}, result, e.res);
    chk({tag, "/carry"}, carry, e.c);
    chk({tag, "/borrow"}, borrow, e.bo);
    chk({tag, "/overflow"}, overflow, e.ov);
    chk({tag, "/zero"}, zero, e.z);
  endtask

  // One idle cycle after done: pulse must drop and outputs must hold.
  task automatic idle_after(input string tag);
    logic [15:0] r;
    r = result;
    @(negedge clk);
    chk({tag, "/done_drop"}, done, 0);
    chk({tag, "/idle_busy"}, busy, 0);
    chk({tag, "/held"}, result, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    chk("rst/result", result, 0);
    chk("rst/flags", {carry, borrow, overflow, zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Plan 1: basic subtract.
    run_op("t1", 1'b1, 16'h1234, 16'h0034, 1'b0);
    chk("t1/exact", result, 16'h1200);
    idle_after("t1");

    // Plan 2: borrow, then signed overflow on subtract.
    run_op("t2a", 1'b1, 16'h0000, 16'h0001, 1'b0);
    chk("t2a/exact", {result, carry, borrow}, {16'hFFFF, 1'b0, 1'b1});
    idle_after("t2a");
    run_op("t2b", 1'b1, 16'h8000, 16'h0001, 1'b0);
    chk("t2b/exact", {result, overflow}, {16'h7FFF, 1'b1});
    idle_after("t2b");

    // Plan 3: add overflow, then add wrap-to-zero.
    run_op("t3a", 1'b0, 16'h7FFF, 16'h0001, 1'b0);
    chk("t3a/exact", {result, overflow, carry}, {16'h8000, 1'b1, 1'b0});
    idle_after("t3a");
    run_op("t3b", 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    chk("t3b/exact", {result, carry, zero}, {16'h0000, 1'b1, 1'b1});
    idle_after("t3b");

    // Plan 4: a == b subtract, then back-to-back start in the DONE cycle.
    run_op("t4a", 1'b1, 16'h5555, 16'h5555, 1'b0);
    chk("t4a/exact", {zero, carry, borrow}, {1'b1, 1'b1, 1'b0});
    run_op("t4b", 1'b1, 16'h0010, 16'h0001, 1'b0);
    chk("t4b/exact", result, 16'h000F);
    idle_after("t4b");

    // Plan 5: start re-asserted while busy is ignored.
    run_op("t5", 1'b0, 16'h0100, 16'h0001, 1'b1);
    chk("t5/exact", result, 16'h0101);
    idle_after("t5");
    for (int i = 0; i < NCHUNK + 2; i++) begin
      @(negedge clk);
      chk("t5/single_done", done, 0);
    end

    // Plan 6: reset in the middle of an op.
    mode  = 1'b0;
    a     = 16'h00F0;
    b     = 16'h0F00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6/busy", busy, 0);
    chk("t6/done", done, 0);
    chk("t6/result", result, 0);
    chk("t6/flags", {carry, borrow, overflow, zero}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NCHUNK + 2; i++) begin
      @(negedge clk);
      chk("t6/no_done", {done, busy}, 0);
    end
    run_op("t6b", 1'b1, 16'h0003, 16'h0002, 1'b0);
    chk("t6b/exact", result, 16'h0001);
    idle_after("t6b");

    // Random ops, mixing idle gaps and back-to-back issue.
    for (int i = 0; i < 60; i++) begin
      logic        m;
      logic [15:0] x, y;
      m = 1'($urandom);
      x = 16'($urandom);
      y = 16'($urandom);
      case ($urandom_range(0, 5))
        0: y = x;
        1: x = 16'h8000;
        2: y = 16'hFFFF;
        default: ;
      endcase
      run_op("rnd", m, x, y, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_after("rnd");
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
